// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
// Operand/product widths, FSM states and a counter-width helper.
package mul_pkg;

   localparam int MUL_W  = 32;
   localparam int PROD_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } stateT;

   // Bits needed to count N iterations; never below 1.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mul_pp_slice.sv
// Sums the K partial products of one multiplier slice.
// Each product is x shifted to its absolute bit position.
module mul_pp_slice
   import mul_pkg::*;
#(
   parameter int K = 4
) (
   input  logic [MUL_W-1:0]  x,
   input  logic [K-1:0]      ySlice,
   input  logic [5:0]        base,
   output logic [PROD_W-1:0] ppSum
);

   logic [PROD_W-1:0] xWide;

   assign xWide = {{(PROD_W-MUL_W){1'b0}}, x};

   always_comb begin
      ppSum = '0;
      for (int j = 0; j < K; j++) begin
         if (ySlice[j]) begin
            ppSum = ppSum + (xWide << (base + 6'(j)));
         end
      end
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative 32x32->64 multiplier sequencer, K multiplier bits per cycle.
// Signed operands are multiplied as magnitudes; sign fixed at the end.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int K = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MUL_W-1:0]  in_x,
   input  logic [MUL_W-1:0]  in_y,
   input  logic              in_signed,
   input  logic              kill,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [PROD_W-1:0] res_prod,
   output logic              busy
);

   localparam int N  = MUL_W / K;
   localparam int CW = clog2(N);

   if (!(K == 1 || K == 2 || K == 4 ||
         K == 8 || K == 16 || K == 32)) begin : gBadK
      $error("mul_seq_ctrl: K must be a power of two dividing 32");
   end

   stateT             state;
   stateT             stateNxt;
   logic [CW-1:0]     cnt;
   logic [MUL_W-1:0]  opX;
   logic [MUL_W-1:0]  opY;
   logic [MUL_W-1:0]  ySh;
   logic              neg;
   logic [PROD_W-1:0] acc;
   logic [PROD_W-1:0] accNxt;
   logic [PROD_W-1:0] ppSum;
   logic [PROD_W-1:0] prod;
   logic [5:0]        base;
   logic              accept;
   logic              lastIter;

   assign base     = 6'(int'(cnt) * K);
   assign ySh      = opY >> base;
   assign accNxt   = acc + ppSum;
   assign lastIter = (int'(cnt) == N - 1);

   mul_pp_slice #(
      .K(K)
   ) uSlice (
      .x     (opX),
      .ySlice(ySh[K-1:0]),
      .base  (base),
      .ppSum (ppSum)
   );

   assign in_ready  = (state == IDLE) && !kill;
   assign accept    = in_valid && in_ready;
   assign res_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign res_prod  = prod;

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (accept)    stateNxt = BUSY;
         BUSY:    if (lastIter)  stateNxt = DONE;
         DONE:    if (res_ready) stateNxt = IDLE;
         default:                stateNxt = IDLE;
      endcase
      // Flush wins over everything, including a DONE handshake.
      if (kill) stateNxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         acc  <= '0;
         opX  <= '0;
         opY  <= '0;
         neg  <= 1'b0;
         prod <= '0;
      end else if (kill) begin
         cnt <= '0;
      end else if (accept) begin
         // Two's-complement negate gives |0x80000000| = 0x80000000.
         opX <= (in_signed && in_x[MUL_W-1]) ? -in_x : in_x;
         opY <= (in_signed && in_y[MUL_W-1]) ? -in_y : in_y;
         neg <= in_signed && (in_x[MUL_W-1] ^ in_y[MUL_W-1]);
         acc <= '0;
         cnt <= '0;
      end else if (state == BUSY) begin
         acc <= accNxt;
         cnt <= lastIter ? '0 : cnt + CW'(1);
         if (lastIter) prod <= neg ? -accNxt : accNxt;
      end
   end

endmodule
